cnoc_mem_bist: RTL

- AXI4 master BIST engine on the CNOC request/response structs; drives the slave port of the dual-port AXI RAM model, or any CNOC slave.
- Writes a deterministic pattern over an address range using INCR bursts, then reads the range back and compares it.
- Reports pass/fail, a saturating error count and the first failing address.
- Used for memory-model bring-up and as an upstream traffic source in subsystem benches.

---
 rtl/cnoc_mem_bist.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cnoc_mem_bist.sv
// CNOC request/response structs and an AXI4 master BIST engine that writes a seeded
// pattern over an address range with INCR bursts, then reads it back and checks it.
package cnoc_pkg;
    localparam int CNOC_DATAW = 64;
    localparam int CNOC_ADDRW = 32;
    localparam int AXI_IDW    = 4;
    localparam int CNOC_USERW = 1;

    typedef struct packed {
        logic [AXI_IDW-1:0]    id;
        logic [CNOC_ADDRW-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [CNOC_USERW-1:0] user;
    } cnoc_ax_s;

    typedef struct packed {
        logic [CNOC_DATAW-1:0]   data;
        logic [CNOC_DATAW/8-1:0] strb;
        logic                    last;
        logic [CNOC_USERW-1:0]   user;
    } cnoc_w_s;

    typedef struct packed {
        logic [AXI_IDW-1:0]    id;
        logic [1:0]            resp;
        logic [CNOC_USERW-1:0] user;
    } cnoc_b_s;

    typedef struct packed {
        logic [AXI_IDW-1:0]    id;
        logic [CNOC_DATAW-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [CNOC_USERW-1:0] user;
    } cnoc_r_s;

    typedef struct packed {
        cnoc_ax_s aw;
        logic     aw_valid;
        cnoc_w_s  w;
        logic     w_valid;
        logic     b_ready;
        cnoc_ax_s ar;
        logic     ar_valid;
        logic     r_ready;
    } cnoc_req_s;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        cnoc_b_s b;
        logic    b_valid;
        cnoc_r_s r;
        logic    r_valid;
    } cnoc_resp_s;
endpackage

module cnoc_mem_bist
    import cnoc_pkg::*;
#(
    parameter int DATA_WIDTH = CNOC_DATAW,
    parameter int ADDR_WIDTH = CNOC_ADDRW,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = AXI_IDW,
    parameter int BURST_LEN  = 16,
    parameter logic [ID_WIDTH-1:0] BIST_ID = '0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_beats,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output cnoc_req_s             req,
    input  cnoc_resp_s            resp
);
    // state | meaning
    // IDLE  | waiting for start after reset
    // AW    | write address offered
    // W     | write beats of the current burst
    // B     | waiting for write response
    // AR    | read address offered
    // R     | read beats being compared
    // DONE  | result valid, waiting for start
    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_e;

    localparam int LANES = DATA_WIDTH / 32;
    localparam int SIZE  = $clog2(STRB_WIDTH);

    state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           total_q;
    logic [31:0]           seed_q;
    logic [15:0]           beat_q;
    logic [8:0]            left_q;
    logic [ADDR_WIDTH-1:0] burst_addr_q;

    logic [15:0]           remain;
    logic [8:0]            burst_beats;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [31:0]           lane_base;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  start_ok;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  burst_end;
    logic                  err_hit;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic                  unused_ok;

    assign remain      = total_q - beat_q;
    assign burst_beats = (remain > 16'(BURST_LEN)) ? 9'(BURST_LEN) : remain[8:0];
    assign beat_addr   = base_q + (ADDR_WIDTH'(beat_q) << SIZE);
    assign lane_base   = seed_q + 32'(beat_q) * 32'(LANES);
    assign burst_end   = (left_q == 9'd1);

    always_comb begin
        pattern = '0;
        for (int j = 0; j < LANES; j++) begin
            pattern[j*32 +: 32] = lane_base + 32'(j);
        end
    end

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign aw_hs    = (state == S_AW) && resp.aw_ready;
    assign w_hs     = (state == S_W)  && resp.w_ready;
    assign b_hs     = (state == S_B)  && resp.b_valid;
    assign ar_hs    = (state == S_AR) && resp.ar_ready;
    assign r_hs     = (state == S_R)  && resp.r_valid;

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign pass = (state == S_DONE) && (err_count == 16'd0);

    // Any combination of data, rresp or last problems on one beat is one error.
    always_comb begin
        err_hit  = 1'b0;
        err_addr = '0;
        if (b_hs) begin
            err_hit  = (resp.b.resp != 2'b00);
            err_addr = burst_addr_q;
        end else if (r_hs) begin
            err_hit  = (resp.r.data != CNOC_DATAW'(pattern)) ||
                       (resp.r.resp != 2'b00) ||
                       (resp.r.last != burst_end);
            err_addr = beat_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (num_beats == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: if (aw_hs) state_nxt = S_W;
            S_W:  if (w_hs && burst_end) state_nxt = S_B;
            S_B: begin
                if (b_hs) begin
                    state_nxt = (beat_q == total_q) ? S_AR : S_AW;
                end
            end
            S_AR: if (ar_hs) state_nxt = S_R;
            S_R: begin
                if (r_hs && burst_end) begin
                    state_nxt = (beat_q + 16'd1 == total_q) ? S_DONE : S_AR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            base_q         <= '0;
            total_q        <= '0;
            seed_q         <= '0;
            beat_q         <= '0;
            left_q         <= '0;
            burst_addr_q   <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (start_ok) begin
                base_q         <= base_addr;
                total_q        <= num_beats;
                seed_q         <= seed;
                beat_q         <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
            end
            if (aw_hs || ar_hs) begin
                left_q       <= burst_beats;
                burst_addr_q <= beat_addr;
            end
            if (w_hs || r_hs) begin
                beat_q <= beat_q + 16'd1;
                left_q <= left_q - 9'd1;
            end
            if (b_hs && beat_q == total_q) begin
                beat_q <= '0;
            end
            if (err_hit) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'd0) begin
                    first_err_addr <= err_addr;
                end
            end
        end
    end

    always_comb begin
        req          = '0;
        req.aw.id    = AXI_IDW'(BIST_ID);
        req.aw.addr  = CNOC_ADDRW'(beat_addr);
        req.aw.len   = 8'(burst_beats - 9'd1);
        req.aw.size  = 3'(SIZE);
        req.aw.burst = 2'b01;
        req.ar       = req.aw;
        req.aw_valid = (state == S_AW);
        req.ar_valid = (state == S_AR);
        req.w.data   = CNOC_DATAW'(pattern);
        req.w.strb   = '1;
        req.w.last   = burst_end;
        req.w_valid  = (state == S_W);
        req.b_ready  = (state == S_B);
        req.r_ready  = (state == S_R);
    end

    assign unused_ok = ^{resp.b.id, resp.b.user, resp.r.id, resp.r.user};

endmodule
